// File: rtl/rf_port_arbiter_pkg.sv
// Shared defaults and round-robin helpers for the register-file port arbiter.
package rf_port_arbiter_pkg;

    // Default register file geometry; must match the attached register file.
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;

    // Pointer width for an N-way arbiter; never narrower than one bit.
    function automatic int unsigned rr_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Search distance of requester idx from the priority pointer, modulo n.
    function automatic int unsigned rr_distance(input int unsigned idx,
                                                input int unsigned ptr,
                                                input int unsigned n);
        return (idx + n - ptr) % n;
    endfunction

endpackage

// File: rtl/rf_port_arbiter_rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant to the first valid at or after
// the pointer (wrapping), pointer moves past the winner on every grant.
module rr_arbiter
    import rf_port_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant
);

    localparam int unsigned IDX_W = rr_idx_w(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_nxt;
    logic             any_valid;

    // Pick the valid requester closest to ptr; grants are suppressed in reset.
    always_comb begin
        int unsigned best_dist;
        int unsigned win;
        best_dist = N;
        win       = 0;
        any_valid = 1'b0;
        grant     = '0;
        ptr_nxt   = ptr;
        for (int unsigned i = 0; i < N; i++) begin
            if (valid[i] && (rr_distance(i, 32'(ptr), N) < best_dist)) begin
                best_dist = rr_distance(i, 32'(ptr), N);
                win       = i;
                any_valid = 1'b1;
            end
        end
        if (any_valid && !rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                grant[i] = (i == win);
            end
            ptr_nxt = IDX_W'((win + 1) % N);
        end
    end

    // Priority pointer: holds when idle, otherwise one past the winner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares the single write and single read port of a register file between
// NUM_REQ requesters. Writes pass straight through on the handshake; read data
// is registered and returned one cycle after grant. No read-after-write
// forwarding: a read in the same cycle as a write to that address sees the
// old value.
module rf_port_arbiter
    import rf_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int unsigned NUM_REQ    = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             w_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  w_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  w_data_i,
    output logic [NUM_REQ-1:0]             w_ready_o,
    input  logic [NUM_REQ-1:0]             r_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  r_addr_i,
    output logic [NUM_REQ-1:0]             r_ready_o,
    output logic [NUM_REQ-1:0]             r_rvalid_o,
    output logic [DATA_WIDTH-1:0]          r_rdata_o,
    output logic                           rf_we_o,
    output logic [ADDR_WIDTH-1:0]          rf_wa_o,
    output logic [DATA_WIDTH-1:0]          rf_wd_o,
    output logic [ADDR_WIDTH-1:0]          rf_ra_o,
    input  logic [DATA_WIDTH-1:0]          rf_rd_i
);

    logic [NUM_REQ-1:0] w_gnt;
    logic [NUM_REQ-1:0] r_gnt;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_w_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (w_valid_i),
        .grant (w_gnt)
    );

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_r_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (r_valid_i),
        .grant (r_gnt)
    );

    assign w_ready_o = w_gnt;
    assign r_ready_o = r_gnt;
    assign rf_we_o   = |w_gnt;

    // Write port mux: granted requester's address/data, zero when idle.
    always_comb begin
        rf_wa_o = '0;
        rf_wd_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                rf_wa_o = w_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                rf_wd_o = w_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read address mux: granted requester's address, zero when idle.
    always_comb begin
        rf_ra_o = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i]) begin
                rf_ra_o = r_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Read response: capture data at the grant edge, tag it with the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid_o <= '0;
            r_rdata_o  <= '0;
        end else begin
            r_rvalid_o <= r_gnt;
            if (|r_gnt) begin
                r_rdata_o <= rf_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter: a 2-requester instance (A) and a
// 3-requester instance (B). Stimulus pushes expected write/read responses;
// negedge monitors pop and compare whenever the DUT presents an output.
module tb_rf_port_arbiter;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_exp_t;

    typedef struct packed {
        logic [2:0]  gnt;
        logic [31:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    wr_exp_t a_wq[$];
    rd_exp_t a_rq[$];
    rd_exp_t b_rq[$];

    // Instance A: 2 requesters
    logic [1:0]  a_w_valid, a_w_ready, a_r_valid, a_r_ready, a_rvalid;
    logic [9:0]  a_w_addr, a_r_addr;
    logic [63:0] a_w_data;
    logic [31:0] a_rdata, a_rf_wd, a_rf_rd;
    logic        a_rf_we;
    logic [4:0]  a_rf_wa, a_rf_ra;
    logic [31:0] a_mem [32];

    // Instance B: 3 requesters, read port exercised
    logic [2:0]  b_w_valid, b_w_ready, b_r_valid, b_r_ready, b_rvalid;
    logic [14:0] b_w_addr, b_r_addr;
    logic [95:0] b_w_data;
    logic [31:0] b_rdata, b_rf_wd, b_rf_rd;
    logic        b_rf_we;
    logic [4:0]  b_rf_wa, b_rf_ra;

    rf_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_REQ    (2)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .w_valid_i  (a_w_valid),
        .w_addr_i   (a_w_addr),
        .w_data_i   (a_w_data),
        .w_ready_o  (a_w_ready),
        .r_valid_i  (a_r_valid),
        .r_addr_i   (a_r_addr),
        .r_ready_o  (a_r_ready),
        .r_rvalid_o (a_rvalid),
        .r_rdata_o  (a_rdata),
        .rf_we_o    (a_rf_we),
        .rf_wa_o    (a_rf_wa),
        .rf_wd_o    (a_rf_wd),
        .rf_ra_o    (a_rf_ra),
        .rf_rd_i    (a_rf_rd)
    );

    rf_port_arbiter #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .NUM_REQ    (3)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .w_valid_i  (b_w_valid),
        .w_addr_i   (b_w_addr),
        .w_data_i   (b_w_data),
        .w_ready_o  (b_w_ready),
        .r_valid_i  (b_r_valid),
        .r_addr_i   (b_r_addr),
        .r_ready_o  (b_r_ready),
        .r_rvalid_o (b_rvalid),
        .r_rdata_o  (b_rdata),
        .rf_we_o    (b_rf_we),
        .rf_wa_o    (b_rf_wa),
        .rf_wd_o    (b_rf_wd),
        .rf_ra_o    (b_rf_ra),
        .rf_rd_i    (b_rf_rd)
    );

    // Register file model for A: reg 0 reads as zero, r5 preloaded to 0x22.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) a_mem[i] <= 32'h0;
            a_mem[5] <= 32'h22;
        end else if (a_rf_we) begin
            a_mem[a_rf_wa] <= a_rf_wd;
        end
    end
    assign a_rf_rd = (a_rf_ra == 5'd0) ? 32'h0 : a_mem[a_rf_ra];

    // Read-only register file model for B: reg k holds 0x100+k, reg 0 reads zero.
    assign b_rf_rd = (b_rf_ra == 5'd0) ? 32'h0 : (32'h100 + {27'h0, b_rf_ra});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got output %h, expected none", name, act);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor A: write handshakes and read responses against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_rf_we || (a_w_ready != 2'b00)) begin
                if (a_wq.size() == 0) begin
                    unexpected("a_write", {a_w_ready, a_rf_wa, a_rf_wd});
                end else begin
                    wr_exp_t e;
                    e = a_wq.pop_front();
                    check("a_wr_grant", {1'b0, a_w_ready}, e.gnt);
                    check("a_wr_we", a_rf_we, 1'b1);
                    check("a_wr_addr", a_rf_wa, e.addr);
                    check("a_wr_data", a_rf_wd, e.data);
                end
            end
            if (a_rvalid != 2'b00) begin
                if (a_rq.size() == 0) begin
                    unexpected("a_read", {a_rvalid, a_rdata});
                end else begin
                    rd_exp_t e;
                    e = a_rq.pop_front();
                    check("a_rd_rvalid", {1'b0, a_rvalid}, e.gnt);
                    check("a_rd_data", a_rdata, e.data);
                end
            end
        end
    end

    // Monitor B: read responses against the queue.
    always @(negedge clk) begin
        if (!rst && (b_rvalid != 3'b000)) begin
            if (b_rq.size() == 0) begin
                unexpected("b_read", {b_rvalid, b_rdata});
            end else begin
                rd_exp_t e;
                e = b_rq.pop_front();
                check("b_rd_rvalid", b_rvalid, e.gnt);
                check("b_rd_data", b_rdata, e.data);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        a_w_valid = 2'b11;  a_r_valid = 2'b11;
        a_w_addr  = {5'd2, 5'd1};
        a_w_data  = {32'hB0, 32'hA0};
        a_r_addr  = {5'd5, 5'd5};
        b_w_valid = 3'b000; b_w_addr = '0; b_w_data = '0;
        b_r_valid = 3'b111;
        b_r_addr  = {5'd7, 5'd2, 5'd1};

        // Reset: no grants or responses regardless of valids
        repeat (2) @(negedge clk);
        check("rst_a_w_ready", a_w_ready, 2'b00);
        check("rst_a_r_ready", a_r_ready, 2'b00);
        check("rst_a_we", a_rf_we, 1'b0);
        check("rst_a_rvalid", a_rvalid, 2'b00);
        check("rst_a_rdata", a_rdata, 32'h0);
        check("rst_b_r_ready", b_r_ready, 3'b000);
        check("rst_b_rvalid", b_rvalid, 3'b000);

        @(posedge clk); #1;
        rst       = 1'b0;
        a_r_valid = 2'b00;
        b_r_valid = 3'b000;

        // Both writers contend for 6 cycles: 01,10,01,10,01,10
        a_w_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) a_wq.push_back('{gnt: 3'b001, addr: 5'd1, data: 32'hA0});
            else            a_wq.push_back('{gnt: 3'b010, addr: 5'd2, data: 32'hB0});
        end
        repeat (6) tick();

        // Req0 writes r3, then reads it back
        a_w_valid = 2'b01;
        a_w_addr[4:0] = 5'd3;  a_w_data[31:0] = 32'hDEADBEEF;
        a_wq.push_back('{gnt: 3'b001, addr: 5'd3, data: 32'hDEADBEEF});
        tick();
        a_w_valid = 2'b00;
        a_r_valid = 2'b01;
        a_r_addr[4:0] = 5'd3;
        a_rq.push_back('{gnt: 3'b001, data: 32'hDEADBEEF});
        @(negedge clk);
        check("a_r3_ra", a_rf_ra, 5'd3);
        check("a_r3_r_ready", a_r_ready, 2'b01);
        tick();

        // Same-cycle write and read of r5: read sees old 0x22, next read sees 0x11
        a_w_valid = 2'b10;
        a_w_addr[9:5] = 5'd5;  a_w_data[63:32] = 32'h11;
        a_r_valid = 2'b10;
        a_r_addr[9:5] = 5'd5;
        a_wq.push_back('{gnt: 3'b010, addr: 5'd5, data: 32'h11});
        a_rq.push_back('{gnt: 3'b010, data: 32'h22});
        tick();
        a_w_valid = 2'b00;
        a_r_valid = 2'b01;
        a_r_addr[4:0] = 5'd5;
        a_rq.push_back('{gnt: 3'b001, data: 32'h11});
        tick();
        a_r_valid = 2'b00;
        tick();
        @(negedge clk);
        check("a_idle_rvalid", a_rvalid, 2'b00);
        check("a_idle_rdata_hold", a_rdata, 32'h11);
        tick();

        // Write r0 is passed through; reading r0 returns zero
        a_w_valid = 2'b01;
        a_w_addr[4:0] = 5'd0;  a_w_data[31:0] = 32'hFFFFFFFF;
        a_wq.push_back('{gnt: 3'b001, addr: 5'd0, data: 32'hFFFFFFFF});
        tick();
        a_w_valid = 2'b00;
        a_r_valid = 2'b10;
        a_r_addr[9:5] = 5'd0;
        a_rq.push_back('{gnt: 3'b010, data: 32'h0});
        tick();
        a_r_valid = 2'b00;
        repeat (2) tick();

        // 3-way: req2 alone first, then all valid -> 0,1,2
        b_r_valid = 3'b100;
        b_rq.push_back('{gnt: 3'b100, data: 32'h107});
        tick();
        b_r_valid = 3'b111;
        b_rq.push_back('{gnt: 3'b001, data: 32'h101});
        b_rq.push_back('{gnt: 3'b010, data: 32'h102});
        b_rq.push_back('{gnt: 3'b100, data: 32'h107});
        repeat (3) tick();
        // This grant to req0 is in flight when reset hits; its response is lost
        tick();
        check("b_pre_rst_rvalid", b_rvalid, 3'b001);
        check("b_pre_rst_rdata", b_rdata, 32'h101);
        #1;
        rst = 1'b1;
        #1;
        check("b_rst_rvalid", b_rvalid, 3'b000);
        check("b_rst_r_ready", b_r_ready, 3'b000);
        repeat (2) tick();
        b_r_valid = 3'b000;
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("b_post_rst_rvalid", b_rvalid, 3'b000);

        check("a_wq_drained", a_wq.size(), 0);
        check("a_rq_drained", a_rq.size(), 0);
        check("b_rq_drained", b_rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
